// File: rtl/mux_n1_rr_reg.sv
// N:1 registered mux with valid/ready handshakes, fixed or round-robin selection, source tagging.
// Define MUX_PARITY_EN to add the registered out_parity output.
module mux_n1_rr_reg #(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode_rr,
    input  logic [SEL_W-1:0]          selector,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
`ifdef MUX_PARITY_EN
    output logic                      out_parity,
`endif
    input  logic                      out_ready
);

    logic             load_en;
    logic             grant_valid;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] rr_ptr;
    logic [WIDTH-1:0] grant_data;

    assign load_en = !out_valid || out_ready;

    // Round-robin search walks downward so the candidate closest to rr_ptr is written last and wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant       = '0;
        if (!mode_rr) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (selector == SEL_W'(i) && in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant       = SEL_W'(i);
                end
            end
        end else begin
            for (int k = CHANNELS - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= CHANNELS) begin
                    idx = idx - CHANNELS;
                end
                if (in_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant       = SEL_W'(idx);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
            in_ready[i] = load_en && grant_valid && (grant == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= '0;
        end else if (load_en) begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_data <= grant_data;
                out_chan <= grant;
                if (mode_rr) begin
                    rr_ptr <= (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
                end
            end
        end
    end

`ifdef MUX_PARITY_EN
    // Parity follows out_data exactly, so it also holds while the beat is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_parity <= 1'b0;
        end else if (load_en && grant_valid) begin
            out_parity <= ^grant_data;
        end
    end
`endif

endmodule

// File: tb/tb_mux_n1_rr_reg.sv
// Self-checking bench for mux_n1_rr_reg: vector table, directed corner sequences, random vs model.
// Parity checks are compiled in when MUX_PARITY_EN is defined.
module tb_mux_n1_rr_reg;

    localparam int CH = 4;

    logic       clk = 1'b0;
    logic       reset;

    logic       mode_rr;
    logic [1:0] selector;
    logic [3:0] in_valid;
    logic [7:0] in_data;
    logic [3:0] in_ready;
    logic       out_valid;
    logic [1:0] out_data;
    logic [1:0] out_chan;
    logic       out_ready;

    logic       mode_rr3;
    logic [1:0] selector3;
    logic [2:0] in_valid3;
    logic [5:0] in_data3;
    logic [2:0] in_ready3;
    logic       out_valid3;
    logic [1:0] out_data3;
    logic [1:0] out_chan3;
    logic       out_ready3;

`ifdef MUX_PARITY_EN
    logic       out_parity;
    logic       out_parity3;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic [7:0] data;
        logic       rdy;
        logic [3:0] exp_ready;
        logic       exp_valid;
        logic [1:0] exp_data;
        logic [1:0] exp_chan;
    } vec_t;

    vec_t vecs[9];

    // Random-phase reference state
    logic       m_valid;
    logic [1:0] m_data;
    logic [1:0] m_chan;
    int         m_ptr;

    always #5 clk = ~clk;

    mux_n1_rr_reg #(.WIDTH(2), .CHANNELS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode_rr   (mode_rr),
        .selector  (selector),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
`ifdef MUX_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_ready (out_ready)
    );

    mux_n1_rr_reg #(.WIDTH(2), .CHANNELS(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .mode_rr   (mode_rr3),
        .selector  (selector3),
        .in_valid  (in_valid3),
        .in_data   (in_data3),
        .in_ready  (in_ready3),
        .out_valid (out_valid3),
        .out_data  (out_data3),
        .out_chan  (out_chan3),
`ifdef MUX_PARITY_EN
        .out_parity(out_parity3),
`endif
        .out_ready (out_ready3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [3:0] v,
                                 input logic [7:0] d, input logic r);
        mode_rr   = m;
        selector  = s;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [1:0] ed,
                               input logic [1:0] ec);
        check({name, " out_valid"}, out_valid, ev);
        check({name, " out_data"}, out_data, ed);
        check({name, " out_chan"}, out_chan, ec);
`ifdef MUX_PARITY_EN
        check({name, " out_parity"}, out_parity, ^ed);
`endif
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    function automatic int modelGrant(input logic m, input logic [1:0] s, input logic [3:0] v,
                                      input int ptr);
        int c;
        if (!m) begin
            return (int'(s) < CH && v[s]) ? int'(s) : -1;
        end
        for (int k = 0; k < CH; k++) begin
            c = (ptr + k) % CH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    initial begin
        int         g;
        logic [3:0] exp_ready;
        logic       load;

        // ch3..ch0 data = 3,2,1,0 for 8'hE4 and 0,1,2,3 for 8'h1B
        vecs[0] = '{1'b0, 2'd2, 4'b1111, 8'hE4, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2};
        vecs[1] = '{1'b0, 2'd1, 4'b0101, 8'hE4, 1'b1, 4'b0000, 1'b0, 2'd2, 2'd2};
        vecs[2] = '{1'b0, 2'd3, 4'b1000, 8'hE4, 1'b0, 4'b1000, 1'b1, 2'd3, 2'd3};
        vecs[3] = '{1'b0, 2'd0, 4'b1111, 8'hE4, 1'b0, 4'b0000, 1'b1, 2'd3, 2'd3};
        vecs[4] = '{1'b0, 2'd0, 4'b1111, 8'hE4, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd0};
        vecs[5] = '{1'b1, 2'd0, 4'b1111, 8'hE4, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd0};
        vecs[6] = '{1'b1, 2'd0, 4'b1111, 8'h1B, 1'b1, 4'b0010, 1'b1, 2'd2, 2'd1};
        vecs[7] = '{1'b1, 2'd0, 4'b0011, 8'h1B, 1'b1, 4'b0001, 1'b1, 2'd3, 2'd0};
        vecs[8] = '{1'b1, 2'd0, 4'b0000, 8'h1B, 1'b1, 4'b0000, 1'b0, 2'd3, 2'd0};

        reset = 1'b1;
        applyStimulus(1'b0, 2'd0, 4'b0000, 8'h00, 1'b0);
        mode_rr3 = 1'b0; selector3 = 2'd0; in_valid3 = 3'b000; in_data3 = 6'd0; out_ready3 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("reset", 1'b0, 2'd0, 2'd0);
        check("reset dut3 out_valid", out_valid3, 1'b0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].data, vecs[i].rdy);
            check($sformatf("vec%0d in_ready", i), in_ready, vecs[i].exp_ready);
            nextEdge();
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                        vecs[i].exp_chan);
        end

        // Reset in the middle of a stalled beat, with rr_ptr left non-zero by the table
        applyStimulus(1'b0, 2'd3, 4'b1000, 8'hE4, 1'b0);
        nextEdge();
        checkOutput("pre-reset held", 1'b1, 2'd3, 2'd3);
        #2 reset = 1'b1;
        #1 checkOutput("async reset", 1'b0, 2'd0, 2'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        applyStimulus(1'b1, 2'd0, 4'b1111, 8'hE4, 1'b1);
        check("post-reset first grant", in_ready, 4'b0001);

        for (int i = 0; i < 8; i++) begin
            nextEdge();
            check($sformatf("rr beat%0d chan", i), out_chan, i % 4);
            check($sformatf("rr beat%0d data", i), out_data, i % 4);
        end

        // Backpressure: beat from ch3 must sit untouched, then drain and refill with no bubble
        applyStimulus(1'b1, 2'd0, 4'b1111, 8'hE4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall%0d in_ready", i), in_ready, 4'b0000);
            nextEdge();
            checkOutput($sformatf("stall%0d", i), 1'b1, 2'd3, 2'd3);
        end
        applyStimulus(1'b1, 2'd0, 4'b1111, 8'hE4, 1'b1);
        check("release in_ready", in_ready, 4'b0001);
        nextEdge();
        checkOutput("release", 1'b1, 2'd0, 2'd0);

        // Three-channel wrap: accept ch0 to move the pointer to 1, then sparse 3'b101
        mode_rr3 = 1'b1; in_valid3 = 3'b001; in_data3 = 6'b10_01_11; out_ready3 = 1'b1;
        #1 check("c3 first in_ready", in_ready3, 3'b001);
        nextEdge();
        check("c3 first chan", out_chan3, 2'd0);
        in_valid3 = 3'b101;
        #1 check("c3 wrap in_ready a", in_ready3, 3'b100);
        nextEdge();
        check("c3 wrap chan a", out_chan3, 2'd2);
        check("c3 wrap data a", out_data3, 2'd2);
        check("c3 wrap in_ready b", in_ready3, 3'b001);
        nextEdge();
        check("c3 wrap chan b", out_chan3, 2'd0);
        check("c3 wrap data b", out_data3, 2'd3);
        mode_rr3 = 1'b0; selector3 = 2'd3; in_valid3 = 3'b111;
        #1 check("c3 bad selector in_ready", in_ready3, 3'b000);
        nextEdge();
        check("c3 bad selector out_valid", out_valid3, 1'b0);
        check("c3 bad selector chan held", out_chan3, 2'd0);

        // Random traffic against the reference model
        reset = 1'b1;
        nextEdge();
        reset = 1'b0;
        m_valid = 1'b0; m_data = 2'd0; m_chan = 2'd0; m_ptr = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          4'($urandom_range(0, 15)), 8'($urandom),
                          $urandom_range(0, 3) != 0);
            g         = modelGrant(mode_rr, selector, in_valid, m_ptr);
            load      = !m_valid || out_ready;
            exp_ready = (load && g >= 0) ? 4'(1 << g) : 4'b0000;
            check($sformatf("rand%0d in_ready", cyc), in_ready, exp_ready);
            checkOutput($sformatf("rand%0d", cyc), m_valid, m_data, m_chan);
            if (load) begin
                m_valid = (g >= 0);
                if (g >= 0) begin
                    m_data = in_data[g*2 +: 2];
                    m_chan = 2'(g);
                    if (mode_rr) m_ptr = (g + 1) % CH;
                end
            end
            nextEdge();
        end
        checkOutput("rand final", m_valid, m_data, m_chan);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
